// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback arbiter constants and requester index enum
//
// Purpose: constants and types shared by the writeback arbiter, its
// round-robin core and its bus interface.
// Ports: none (package).

package wb_pkg;

  // Default number of writeback requesters (ALU, LSU, CSR).
  localparam int NUM_WB_PORTS = 3;

  // Width of the saturating contention counter.
  localparam int CONFLICT_W = 16;

  // Round-robin pointer width; covers up to four requesters.
  localparam int RR_PTR_W = 2;

  // Requester indices on the writeback bus.
  typedef enum logic [RR_PTR_W-1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_CSR = 2'd2
  } wb_port_e;

  // True when two or more requesters are valid. Callers zero-pad their
  // request vector to four bits.
  function automatic logic is_conflict(input logic [3:0] valid);
    return $countones(valid) >= 2;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback request bus and register-file write port
//
// Purpose: bundles the per-requester writeback handshake and the registered
// register-file write port.
// Ports (signals):
//   req_valid       [NUM_PORTS]            request from each requester
//   req_addr        [NUM_PORTS][ADDR_SIZE] destination register per requester
//   req_data        [NUM_PORTS][XLEN]      write data per requester
//   req_ready       [NUM_PORTS]            one-hot grant back to requesters
//   rf_write_enable                        register-file write strobe
//   rf_write_addr   [ADDR_SIZE]            register-file write address
//   rf_write_data   [XLEN]                 register-file write data
// Modports: master = requesters / register file side, slave = arbiter.

interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 5,
  parameter int NUM_PORTS = NUM_WB_PORTS
);

  logic [NUM_PORTS-1:0]                req_valid;
  logic [NUM_PORTS-1:0][ADDR_SIZE-1:0] req_addr;
  logic [NUM_PORTS-1:0][XLEN-1:0]      req_data;
  logic [NUM_PORTS-1:0]                req_ready;

  logic                                rf_write_enable;
  logic [ADDR_SIZE-1:0]                rf_write_addr;
  logic [XLEN-1:0]                     rf_write_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  rf_write_enable,
    input  rf_write_addr,
    input  rf_write_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output rf_write_enable,
    output rf_write_addr,
    output rf_write_data
  );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// rtl/wb_arbiter_rr_arbiter.sv - round-robin grant core with its priority pointer
//
// Purpose: combinational round-robin grant over NUM_PORTS requests, plus the
// rr_ptr register naming the highest-priority requester.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset; also suppresses grants
//   block      suppresses grants and freezes the pointer (pipeline flush)
//   req        [NUM_PORTS] request vector
//   grant      [NUM_PORTS] one-hot grant, only to a requesting index
//   grant_any  a grant (and therefore a transfer) happens this cycle
//   grant_idx  [RR_PTR_W] index of the granted requester

module rr_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_WB_PORTS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 block,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 grant_any,
  output logic [RR_PTR_W-1:0]  grant_idx
);

  logic [RR_PTR_W-1:0] rr_ptr;
  logic [RR_PTR_W-1:0] rr_ptr_next;
  logic [RR_PTR_W-1:0] cand;

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_PORTS); first requester found wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!rst && !block) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = RR_PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
        if (!grant_any && req[cand]) begin
          grant[cand] = 1'b1;
          grant_any   = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // The winner drops to lowest priority; the pointer only ever holds a
  // valid index because it is always reduced modulo NUM_PORTS.
  always_comb begin
    rr_ptr_next = rr_ptr;
    if (grant_any) begin
      rr_ptr_next = RR_PTR_W'((int'(grant_idx) + 1) % NUM_PORTS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= WB_ALU;
    end else begin
      rr_ptr <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: round-robin grant, registered RF write, contention counter
//
// Purpose: arbitrates writeback requests onto a single register-file write
// port with one cycle of latency, and counts contention cycles.
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   flush           pipeline flush; no grant this cycle, no write next cycle
//   bus             wb_arbiter_if.slave: requests in, grants and RF write out
//   conflict_count  [CONFLICT_W] saturating count of cycles with >=2 requests

module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 5,
  parameter int NUM_PORTS = NUM_WB_PORTS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  wb_arbiter_if.slave           bus,
  output logic [CONFLICT_W-1:0] conflict_count
);

  if (NUM_PORTS < 2 || NUM_PORTS > 4) begin : g_bad_num_ports
    $error("wb_arbiter: NUM_PORTS must be in 2..4");
  end

  logic [NUM_PORTS-1:0] grant;
  logic                 grant_any;
  logic [RR_PTR_W-1:0]  grant_idx;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [XLEN-1:0]      sel_data;
  logic                 conflict;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .block     (flush),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;

  assign sel_addr = bus.req_addr[grant_idx];
  assign sel_data = bus.req_data[grant_idx];

  // Writes to x0 are accepted but never reach the register file; the
  // address/data registers also keep their previous contents in that case.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_write_enable <= 1'b0;
      bus.rf_write_addr   <= '0;
      bus.rf_write_data   <= '0;
    end else begin
      bus.rf_write_enable <= 1'b0;
      if (grant_any && sel_addr != '0) begin
        bus.rf_write_enable <= 1'b1;
        bus.rf_write_addr   <= sel_addr;
        bus.rf_write_data   <= sel_data;
      end
    end
  end

  // Contention is counted on raw requests, so flush cycles count too.
  assign conflict = is_conflict(4'(bus.req_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_count <= '0;
    end else if (conflict && conflict_count != '1) begin
      conflict_count <= conflict_count + CONFLICT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard testbench for wb_arbiter

module tb_wb_arbiter;

  localparam int XLEN      = 32;
  localparam int ADDR_SIZE = 5;
  localparam int NUM_PORTS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] conflict_count;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int cyc;
  } grant_t;

  typedef struct {
    logic [ADDR_SIZE-1:0] addr;
    logic [XLEN-1:0]      data;
    int                   cyc;
  } write_t;

  grant_t grant_q[$];
  write_t write_q[$];
  grant_t mg;
  write_t mw;

  wb_arbiter_if #(.XLEN(XLEN), .ADDR_SIZE(ADDR_SIZE), .NUM_PORTS(NUM_PORTS)) bus ();

  wb_arbiter #(
    .XLEN      (XLEN),
    .ADDR_SIZE (ADDR_SIZE),
    .NUM_PORTS (NUM_PORTS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .bus            (bus.slave),
    .conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expected grants/writes tagged with the cycle they must
  // appear in, and flags anything unexpected or missed.
  always @(negedge clk) begin
    while (grant_q.size() > 0 && grant_q[0].cyc < cyc) begin
      mg = grant_q.pop_front();
      chk("grant_missing_cycle", 64'(cyc), 64'(mg.cyc));
    end
    while (write_q.size() > 0 && write_q[0].cyc < cyc) begin
      mw = write_q.pop_front();
      chk("write_missing_cycle", 64'(cyc), 64'(mw.cyc));
    end
    if (bus.req_ready != '0) begin
      if (grant_q.size() > 0 && grant_q[0].cyc == cyc) begin
        mg = grant_q.pop_front();
        chk("grant_onehot", 64'(bus.req_ready), 64'(1) << mg.idx);
      end else begin
        chk("grant_unexpected", 64'(bus.req_ready), 64'(0));
      end
    end
    if (bus.rf_write_enable) begin
      if (write_q.size() > 0 && write_q[0].cyc == cyc) begin
        mw = write_q.pop_front();
        chk("write_addr", 64'(bus.rf_write_addr), 64'(mw.addr));
        chk("write_data", 64'(bus.rf_write_data), 64'(mw.data));
      end else begin
        chk("write_unexpected", 64'(bus.rf_write_enable), 64'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    flush = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [ADDR_SIZE-1:0] a, input logic [XLEN-1:0] d);
    bus.req_valid[p] = 1'b1;
    bus.req_addr[p]  = a;
    bus.req_data[p]  = d;
  endtask

  task automatic exp_grant(input int p, input logic [ADDR_SIZE-1:0] a, input logic [XLEN-1:0] d,
                           input bit writes);
    grant_t g;
    write_t w;
    g.idx = p;
    g.cyc = cyc;
    grant_q.push_back(g);
    if (writes) begin
      w.addr = a;
      w.data = d;
      w.cyc  = cyc + 1;
      write_q.push_back(w);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = '1;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // Reset with all requests high: no grants, no counting.
    repeat (3) step();
    @(negedge clk);
    chk("reset_we", 64'(bus.rf_write_enable), 64'(0));
    chk("reset_addr", 64'(bus.rf_write_addr), 64'(0));
    chk("reset_data", 64'(bus.rf_write_data), 64'(0));
    chk("reset_conflict", 64'(conflict_count), 64'(0));
    step();
    rst = 1'b0;
    idle();

    // All three held after reset: grants 0,1,2 on consecutive cycles.
    step();
    set_req(0, 5'd1, 32'hA000_0000);
    set_req(1, 5'd2, 32'hA000_0001);
    set_req(2, 5'd3, 32'hA000_0002);
    exp_grant(0, 5'd1, 32'hA000_0000, 1);
    step();
    bus.req_valid[0] = 1'b0;
    exp_grant(1, 5'd2, 32'hA000_0001, 1);
    step();
    bus.req_valid[1] = 1'b0;
    exp_grant(2, 5'd3, 32'hA000_0002, 1);
    step();
    idle();
    @(negedge clk);
    chk("conflict_after_rr", 64'(conflict_count), 64'(2));

    // Single ALU request (pointer is back at 0).
    step();
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    exp_grant(0, 5'd5, 32'hDEAD_BEEF, 1);
    step();
    idle();
    step();
    @(negedge clk);
    chk("idle_we", 64'(bus.rf_write_enable), 64'(0));
    chk("hold_addr", 64'(bus.rf_write_addr), 64'(5));
    chk("hold_data", 64'(bus.rf_write_data), 64'(32'hDEAD_BEEF));

    // x0 write from LSU (pointer 1): accepted, no RF write, pointer -> 2.
    step();
    set_req(1, 5'd0, 32'h1);
    exp_grant(1, 5'd0, 32'h1, 0);
    step();
    set_req(0, 5'd7, 32'hB000_0000);
    set_req(1, 5'd8, 32'hB000_0001);
    set_req(2, 5'd9, 32'hB000_0002);
    exp_grant(2, 5'd9, 32'hB000_0002, 1);
    @(negedge clk);
    chk("x0_we", 64'(bus.rf_write_enable), 64'(0));
    step();
    bus.req_valid[2] = 1'b0;
    exp_grant(0, 5'd7, 32'hB000_0000, 1);
    step();
    bus.req_valid[0] = 1'b0;
    exp_grant(1, 5'd8, 32'hB000_0001, 1);
    step();
    bus.req_valid[1] = 1'b0;
    set_req(2, 5'd10, 32'hC000_0002);
    exp_grant(2, 5'd10, 32'hC000_0002, 1);
    step();
    idle();
    @(negedge clk);
    chk("conflict_after_x0", 64'(conflict_count), 64'(4));

    // Flush with ALU and CSR pending (pointer 0): no grant, then ALU.
    step();
    set_req(0, 5'd11, 32'hD000_0000);
    set_req(2, 5'd12, 32'hD000_0002);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_grant(0, 5'd11, 32'hD000_0000, 1);
    @(negedge clk);
    chk("flush_we", 64'(bus.rf_write_enable), 64'(0));
    step();
    bus.req_valid[0] = 1'b0;
    exp_grant(2, 5'd12, 32'hD000_0002, 1);
    step();
    idle();
    @(negedge clk);
    chk("conflict_after_flush", 64'(conflict_count), 64'(6));

    // Reset mid-stream: pointer at 1 and LSU pending when rst rises.
    step();
    set_req(0, 5'd13, 32'hE000_0000);
    set_req(1, 5'd14, 32'hE000_0001);
    exp_grant(0, 5'd13, 32'hE000_0000, 1);
    step();
    bus.req_valid[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("midrst_we", 64'(bus.rf_write_enable), 64'(0));
    chk("midrst_addr", 64'(bus.rf_write_addr), 64'(0));
    chk("midrst_conflict", 64'(conflict_count), 64'(0));
    step();
    set_req(0, 5'd15, 32'hF000_0000);
    set_req(1, 5'd16, 32'hF000_0001);
    exp_grant(0, 5'd15, 32'hF000_0000, 1);
    step();
    bus.req_valid[0] = 1'b0;
    exp_grant(1, 5'd16, 32'hF000_0001, 1);
    step();
    idle();

    // Saturation: counter is 1 here; contention under flush, no grants.
    bus.req_valid = '1;
    flush = 1'b1;
    repeat (65533) step();
    @(negedge clk);
    chk("conflict_fffe", 64'(conflict_count), 64'(16'hFFFE));
    step();
    @(negedge clk);
    chk("conflict_ffff", 64'(conflict_count), 64'(16'hFFFF));
    repeat (4465) step();
    @(negedge clk);
    chk("conflict_saturated", 64'(conflict_count), 64'(16'hFFFF));
    step();
    idle();

    repeat (3) step();
    chk("grant_q_left", 64'(grant_q.size()), 64'(0));
    chk("write_q_left", 64'(write_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter ADDR_SIZE, default 5, register address width.
REQ-003 Parameter NUM_PORTS, default 3, number of writeback requesters; index 0 ALU, 1 LSU, 2 CSR.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  pipeline flush; drops the output stage and blocks grants this cycle.
REQ-007 req_valid  input  NUM_PORTS  per-requester writeback request.
REQ-008 req_addr  input  NUM_PORTS x ADDR_SIZE  per-requester destination register.
REQ-009 req_data  input  NUM_PORTS x XLEN  per-requester write data.
REQ-010 req_ready  output  NUM_PORTS  per-requester grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-011 rf_write_enable  output  1  registered write strobe to the register file.
REQ-012 rf_write_addr  output  ADDR_SIZE  registered write address.
REQ-013 rf_write_data  output  XLEN  registered write data.
REQ-014 conflict_count  output  16  saturating count of cycles with two or more req_valid bits high.

Function
REQ-015 req_ready is combinational; at most one bit is high per cycle, and only for a requester whose req_valid is high.
REQ-016 req_ready is all-zero while rst or flush is high.
REQ-017 Arbitration is round-robin: a 2-bit pointer rr_ptr names the highest-priority index; the search proceeds rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
REQ-018 After a transfer from index i, rr_ptr becomes (i+1) mod NUM_PORTS on the next edge; with no transfer, rr_ptr holds.
REQ-019 A requester holds req_valid, req_addr and req_data stable until accepted; no starvation: a held request is granted within NUM_PORTS cycles without flush.
REQ-020 Latency: a transfer in cycle N drives rf_write_enable=1 with the accepted addr/data in cycle N+1 for exactly one cycle.
REQ-021 A transfer with req_addr==0 is accepted (ready high, pointer advances) but yields rf_write_enable=0 in cycle N+1.
REQ-022 With no transfer in cycle N, rf_write_enable=0 in cycle N+1; rf_write_addr/rf_write_data hold their last values.
REQ-023 flush high in cycle N forces rf_write_enable=0 in cycle N+1, leaves rr_ptr unchanged, and performs no transfer in cycle N.
REQ-024 conflict_count increments by 1 on each edge where popcount(req_valid)>=2 and rst is low, including flush cycles; it saturates at 16'hFFFF.
REQ-025 NUM_PORTS is limited to 2..4; other values are an elaboration error.

Reset
REQ-026 While rst is high at an edge: rf_write_enable=0, rf_write_addr=0, rf_write_data=0, rr_ptr=0, conflict_count=0.
REQ-027 rst asserted mid-operation discards any transfer in that cycle; the first post-reset grant favours index 0.

Structure
REQ-028 Shared package wb_pkg holds NUM_WB_PORTS=3, the port-index enum (WB_ALU, WB_LSU, WB_CSR) and the conflict counter width constant.
REQ-029 One sub-module, rr_arbiter, owns rr_ptr and the combinational round-robin grant; wb_arbiter owns the output stage and counter.

Verification
REQ-030 Single request: ALU valid, addr 5, data 32'hDEADBEEF -> ready[0] same cycle; next cycle rf_write_enable=1, addr 5, data 32'hDEADBEEF.
REQ-031 All three valid and held after reset -> grants in order 0,1,2 on consecutive cycles; conflict_count=2 after the third grant.
REQ-032 x0 write: LSU valid, addr 0, data 32'h1 -> ready[1]=1, next cycle rf_write_enable=0, rr_ptr=2.
REQ-033 Flush: ALU and CSR valid with flush=1 for one cycle -> no ready, rf_write_enable=0 next cycle; cycle after flush grants ALU.
REQ-034 Reset mid-stream: rst during an accepted LSU transfer -> rf_write_enable=0, conflict_count=0, next grant goes to index 0.
REQ-035 Saturation: force 70000 contention cycles -> conflict_count holds 16'hFFFF.
